// File: rtl/unidade_controle_jogo.sv
`default_nettype none
// ============================================================================
// Module  : unidade_controle_jogo
// Purpose : Moore control unit for the memory game. It clears the round and
//           address counters, waits for each player move, checks it against
//           memory, then records one new move per round, advances to the next
//           round and reports the final result. It also owns the per-move
//           timeout counter.
// Ports   : clock, reset         - clock, synchronous active-high reset
//           jogar                - start/restart request (level)
//           jogada               - one-cycle "button pressed" pulse
//           igual                - registered move matches memory word
//           fim_rodada           - address counter reached round counter
//           fim_jogo             - round counter reached last round
//           zera_*/conta_*       - datapath counter controls
//           zera_registro, registra_jogada, escreve_memoria - move register
//                                  and memory controls
//           pronto/ganhou/perdeu - game result
//           db_timeout, db_estado - debug outputs
// Revision: 1.0 - initial release
// ============================================================================
module unidade_controle_jogo #(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int TIMEOUT_BITS   = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim_rodada,
  input  logic       fim_jogo,
  output logic       zera_endereco,
  output logic       conta_endereco,
  output logic       zera_rodada,
  output logic       conta_rodada,
  output logic       zera_registro,
  output logic       registra_jogada,
  output logic       escreve_memoria,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  localparam logic [3:0] INICIAL         = 4'h0;
  localparam logic [3:0] PREPARACAO      = 4'h1;
  localparam logic [3:0] INICIA_RODADA   = 4'h2;
  localparam logic [3:0] ESPERA_JOGADA   = 4'h3;
  localparam logic [3:0] REGISTRA_JOGADA = 4'h4;
  localparam logic [3:0] COMPARA_JOGADA  = 4'h5;
  localparam logic [3:0] PROXIMA_JOGADA  = 4'h6;
  localparam logic [3:0] AVANCA_NOVA     = 4'h7;
  localparam logic [3:0] ESPERA_NOVA     = 4'h8;
  localparam logic [3:0] REGISTRA_NOVA   = 4'h9;
  localparam logic [3:0] GRAVA_MEMORIA   = 4'hA;
  localparam logic [3:0] PROXIMA_RODADA  = 4'hB;
  localparam logic [3:0] FIM_ACERTOU     = 4'hC;
  localparam logic [3:0] FIM_ERROU       = 4'hD;
  localparam logic [3:0] FIM_TIMEOUT     = 4'hE;

  // Last count value of a wait; reached on the TIMEOUT_CICLOS-th wait cycle.
  localparam logic [TIMEOUT_BITS-1:0] LIMITE = TIMEOUT_BITS'(TIMEOUT_CICLOS - 1);

  logic [3:0]              estado;
  logic [3:0]              proximo;
  logic [TIMEOUT_BITS-1:0] contagem;
  logic                    esperando;
  logic                    timeout;

  assign esperando = (estado == ESPERA_JOGADA) || (estado == ESPERA_NOVA);
  assign timeout   = (contagem == LIMITE);

  // Timeout counter: runs only while waiting for a move, saturates at the
  // limit, and is cleared in every other state.
  always_ff @(posedge clock) begin
    if (reset) begin
      contagem <= '0;
    end else if (esperando) begin
      if (!timeout) begin
        contagem <= contagem + 1'b1;
      end
    end else begin
      contagem <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
    end else begin
      estado <= proximo;
    end
  end

  always_comb begin
    proximo = INICIAL;
    case (estado)
      INICIAL:         proximo = jogar ? PREPARACAO : INICIAL;
      PREPARACAO:      proximo = INICIA_RODADA;
      INICIA_RODADA:   proximo = ESPERA_JOGADA;
      // A move arriving on the last allowed cycle still counts.
      ESPERA_JOGADA:   proximo = jogada  ? REGISTRA_JOGADA :
                                 timeout ? FIM_TIMEOUT : ESPERA_JOGADA;
      REGISTRA_JOGADA: proximo = COMPARA_JOGADA;
      COMPARA_JOGADA:  proximo = !igual     ? FIM_ERROU   :
                                 fim_rodada ? AVANCA_NOVA : PROXIMA_JOGADA;
      PROXIMA_JOGADA:  proximo = ESPERA_JOGADA;
      AVANCA_NOVA:     proximo = ESPERA_NOVA;
      ESPERA_NOVA:     proximo = jogada  ? REGISTRA_NOVA :
                                 timeout ? FIM_TIMEOUT : ESPERA_NOVA;
      REGISTRA_NOVA:   proximo = GRAVA_MEMORIA;
      GRAVA_MEMORIA:   proximo = fim_jogo ? FIM_ACERTOU : PROXIMA_RODADA;
      PROXIMA_RODADA:  proximo = INICIA_RODADA;
      // Restart leaves the FIM state, so a held jogar restarts only once.
      FIM_ACERTOU,
      FIM_ERROU,
      FIM_TIMEOUT:     proximo = jogar ? PREPARACAO : estado;
      default:         proximo = INICIAL;
    endcase
  end

  // Moore outputs decoded from the state register only.
  assign zera_rodada     = (estado == PREPARACAO);
  assign zera_registro   = (estado == PREPARACAO);
  assign zera_endereco   = (estado == PREPARACAO) || (estado == INICIA_RODADA);
  assign conta_endereco  = (estado == PROXIMA_JOGADA) || (estado == AVANCA_NOVA);
  assign conta_rodada    = (estado == PROXIMA_RODADA);
  assign registra_jogada = (estado == REGISTRA_JOGADA) || (estado == REGISTRA_NOVA);
  assign escreve_memoria = (estado == GRAVA_MEMORIA);
  assign pronto          = (estado == FIM_ACERTOU) || (estado == FIM_ERROU) ||
                           (estado == FIM_TIMEOUT);
  assign ganhou          = (estado == FIM_ACERTOU);
  assign perdeu          = (estado == FIM_ERROU) || (estado == FIM_TIMEOUT);
  assign db_timeout      = (estado == FIM_TIMEOUT);
  assign db_estado       = estado;

endmodule
`default_nettype wire
